// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: result-source select, load funct3
// codes and the stage state.
package writeback_stage_pkg;

    typedef enum logic [2:0] {
        RS_ALU    = 3'd0,
        RS_MEM    = 3'd1,
        RS_PC4    = 3'd2,
        RS_UIMM   = 3'd3,
        RS_PCUIMM = 3'd4
    } result_src_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_e;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Aligns the addressed byte/halfword/word of a raw load word to bit 0 and
// sign- or zero-extends it to XLEN.
module load_extend
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] ext
);

    logic [2:0]      off;
    logic [2:0]      byte_idx;
    logic [XLEN-1:0] shifted;

    // On a 32-bit datapath only the low two address bits select within the word.
    assign off = (XLEN == 64) ? offset : {1'b0, offset[1:0]};

    always_comb begin
        byte_idx = off & 3'b100;
        case (funct3)
            F3_LB, F3_LBU: byte_idx = off;
            F3_LH, F3_LHU: byte_idx = off & 3'b110;
            default:       byte_idx = off & 3'b100;
        endcase

        shifted = raw >> {byte_idx, 3'b000};

        case (funct3)
            F3_LB:   ext = XLEN'($signed(shifted[7:0]));
            F3_LBU:  ext = XLEN'(shifted[7:0]);
            F3_LH:   ext = XLEN'($signed(shifted[15:0]));
            F3_LHU:  ext = XLEN'(shifted[15:0]);
            default: ext = XLEN'($signed(shifted[31:0]));
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered writeback stage: accepts retiring instructions, waits for load
// data when needed, selects the result and issues a one-cycle regfile write.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RESULT_SRC_W = 3,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                    iClk,
    input  logic                    iRstN,
    input  logic                    iValidM,
    output logic                    oReadyM,
    input  logic [RESULT_SRC_W-1:0] iResultSrcM,
    input  logic [2:0]              iFunct3M,
    input  logic [XLEN-1:0]         iAluResultM,
    input  logic [XLEN-1:0]         iPCM,
    input  logic [XLEN-1:0]         iUpperImmM,
    input  logic [REG_ADDR_W-1:0]   iRdM,
    input  logic                    iRegWriteM,
    input  logic                    iMemRValid,
    input  logic [XLEN-1:0]         iMemRData,
    input  logic                    iFlushW,
    output logic                    oRegWriteW,
    output logic [REG_ADDR_W-1:0]   oRdW,
    output logic [XLEN-1:0]         oRegDataInW,
    output logic                    oBusyW
);

    wb_state_e               state_reg, state_next;
    logic [2:0]              funct3_reg;
    logic [2:0]              offset_reg;
    logic [REG_ADDR_W-1:0]   rd_reg;
    logic                    regwrite_reg;

    logic                    regwrite_w_reg;
    logic [REG_ADDR_W-1:0]   rd_w_reg;
    logic [XLEN-1:0]         data_w_reg;

    logic                    accept;
    logic                    is_load;
    logic                    issue;
    logic [RESULT_SRC_W-1:0] sel_src;
    logic [REG_ADDR_W-1:0]   sel_rd;
    logic                    sel_regwrite;
    logic [XLEN-1:0]         load_data;
    logic [XLEN-1:0]         result;

    assign oReadyM = (state_reg == WB_IDLE);
    assign oBusyW  = (state_reg == WB_WAIT);
    assign accept  = iValidM && oReadyM;
    assign is_load = (iResultSrcM == RESULT_SRC_W'(RS_MEM));

    // Non-loads retire straight from the M-side inputs; loads from the held copy.
    assign issue = !iFlushW &&
                   ((accept && !is_load) || (state_reg == WB_WAIT && iMemRValid));

    assign sel_src      = (state_reg == WB_WAIT) ? RESULT_SRC_W'(RS_MEM) : iResultSrcM;
    assign sel_rd       = (state_reg == WB_WAIT) ? rd_reg : iRdM;
    assign sel_regwrite = (state_reg == WB_WAIT) ? regwrite_reg : iRegWriteM;

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .funct3(funct3_reg),
        .offset(offset_reg),
        .raw   (iMemRData),
        .ext   (load_data)
    );

    always_comb begin
        case (sel_src)
            RESULT_SRC_W'(RS_MEM):    result = load_data;
            RESULT_SRC_W'(RS_PC4):    result = iPCM + XLEN'(4);
            RESULT_SRC_W'(RS_UIMM):   result = iUpperImmM;
            RESULT_SRC_W'(RS_PCUIMM): result = iPCM + iUpperImmM;
            default:                  result = iAluResultM;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WB_IDLE: if (accept && is_load && !iFlushW) state_next = WB_WAIT;
            WB_WAIT: if (iFlushW || iMemRValid)         state_next = WB_IDLE;
            default:                                    state_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_reg    <= WB_IDLE;
            funct3_reg   <= '0;
            offset_reg   <= '0;
            rd_reg       <= '0;
            regwrite_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                funct3_reg   <= iFunct3M;
                offset_reg   <= iAluResultM[2:0];
                rd_reg       <= iRdM;
                regwrite_reg <= iRegWriteM;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            regwrite_w_reg <= 1'b0;
            rd_w_reg       <= '0;
            data_w_reg     <= '0;
        end else begin
            regwrite_w_reg <= issue && sel_regwrite;
            if (issue) begin
                rd_w_reg   <= sel_rd;
                data_w_reg <= result;
            end
        end
    end

    assign oRegWriteW  = regwrite_w_reg;
    assign oRdW        = rd_w_reg;
    assign oRegDataInW = data_w_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus pushes expected writes, a
// negedge monitor pops and compares every register-file write pulse.
module tb_writeback_stage;

    logic        iClk;
    logic        iRstN;
    logic        iValidM;
    logic        oReadyM;
    logic [2:0]  iResultSrcM;
    logic [2:0]  iFunct3M;
    logic [31:0] iAluResultM;
    logic [31:0] iPCM;
    logic [31:0] iUpperImmM;
    logic [4:0]  iRdM;
    logic        iRegWriteM;
    logic        iMemRValid;
    logic [31:0] iMemRData;
    logic        iFlushW;
    logic        oRegWriteW;
    logic [4:0]  oRdW;
    logic [31:0] oRegDataInW;
    logic        oBusyW;

    writeback_stage #(
        .XLEN(32),
        .RESULT_SRC_W(3),
        .REG_ADDR_W(5)
    ) dut (
        .iClk       (iClk),
        .iRstN      (iRstN),
        .iValidM    (iValidM),
        .oReadyM    (oReadyM),
        .iResultSrcM(iResultSrcM),
        .iFunct3M   (iFunct3M),
        .iAluResultM(iAluResultM),
        .iPCM       (iPCM),
        .iUpperImmM (iUpperImmM),
        .iRdM       (iRdM),
        .iRegWriteM (iRegWriteM),
        .iMemRValid (iMemRValid),
        .iMemRData  (iMemRData),
        .iFlushW    (iFlushW),
        .oRegWriteW (oRegWriteW),
        .oRdW       (oRdW),
        .oRegDataInW(oRegDataInW),
        .oBusyW     (oBusyW)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: result-source and load rules computed with plain arithmetic.
    function automatic logic [31:0] model(input int src, input int f3, input logic [31:0] alu,
                                          input logic [31:0] pc, input logic [31:0] imm,
                                          input logic [31:0] data);
        int unsigned off, w, bv, hv;
        off = alu[1:0];
        w   = data;
        bv  = (w >> (8 * off)) % 256;
        hv  = (w >> (16 * (off / 2))) % 65536;
        case (src)
            1: begin
                case (f3)
                    0:       return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
                    4:       return bv;
                    1:       return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
                    5:       return hv;
                    default: return w;
                endcase
            end
            2:       return pc + 32'd4;
            3:       return imm;
            4:       return pc + imm;
            default: return alu;
        endcase
    endfunction

    // Monitor: every write pulse must match the oldest expected write and cycle.
    always @(negedge iClk) begin
        if (oRegWriteW) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write actual rd=%0d data=%h required no write (cycle %0d)",
                         oRdW, oRegDataInW, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd", 32'(oRdW), 32'(e.rd));
                chk("wb_data", oRegDataInW, e.data);
                chk("wb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] src, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                         input logic flush, input logic [31:0] req);
        chk("ready_on_issue", 32'(oReadyM), 32'd1);
        iValidM     = 1'b1;
        iResultSrcM = src;
        iFunct3M    = 3'(($urandom_range(0, 7)));
        iAluResultM = alu;
        iPCM        = pc;
        iUpperImmM  = imm;
        iRdM        = rd;
        iRegWriteM  = rw;
        iFlushW     = flush;
        if (rw && !flush) push_exp(rd, req);
        @(posedge iClk); #1;
        iValidM = 1'b0;
        iFlushW = 1'b0;
    endtask

    // mode 0: normal, 1: flush together with the response, 2: flush at accept
    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input logic rw, input int waitc, input int mode,
                        input logic [31:0] req);
        iValidM     = 1'b1;
        iResultSrcM = 3'd1;
        iFunct3M    = f3;
        iAluResultM = addr;
        iPCM        = $urandom;
        iUpperImmM  = $urandom;
        iRdM        = rd;
        iRegWriteM  = rw;
        iFlushW     = (mode == 2);
        @(posedge iClk); #1;
        iValidM = 1'b0;
        iFlushW = 1'b0;
        iAluResultM = $urandom;
        iRdM        = 5'($urandom);
        if (mode == 2) begin
            chk("ready_after_drop", 32'(oReadyM), 32'd1);
            chk("busy_after_drop", 32'(oBusyW), 32'd0);
            return;
        end
        for (int i = 0; i < waitc; i++) begin
            chk("wait_ready", 32'(oReadyM), 32'd0);
            chk("wait_busy", 32'(oBusyW), 32'd1);
            @(posedge iClk); #1;
        end
        chk("resp_busy", 32'(oBusyW), 32'd1);
        iMemRValid = 1'b1;
        iMemRData  = data;
        iFlushW    = (mode == 1);
        if (mode == 0 && rw) push_exp(rd, req);
        @(posedge iClk); #1;
        iMemRValid = 1'b0;
        iFlushW    = 1'b0;
        iMemRData  = $urandom;
        chk("post_ready", 32'(oReadyM), 32'd1);
        chk("post_busy", 32'(oBusyW), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int          r, src, f3, wc, mode;
    logic        rw, fl;
    logic [31:0] a, p, im, d;
    logic [4:0]  rd;

    initial begin
        iRstN = 1'b0; iValidM = 1'b0; iResultSrcM = '0; iFunct3M = '0; iAluResultM = '0;
        iPCM = '0; iUpperImmM = '0; iRdM = '0; iRegWriteM = 1'b0; iMemRValid = 1'b0;
        iMemRData = '0; iFlushW = 1'b0;
        idle(3);
        chk("rst_regwrite", 32'(oRegWriteW), 32'd0);
        chk("rst_rd", 32'(oRdW), 32'd0);
        chk("rst_data", oRegDataInW, 32'd0);
        chk("rst_busy", 32'(oBusyW), 32'd0);
        chk("rst_ready", 32'(oReadyM), 32'd1);
        @(negedge iClk) iRstN = 1'b1;
        @(posedge iClk); #1;

        issue(3'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 32'h0000_1234);
        idle(2);
        issue(3'd2, 32'h0, 32'hFFFF_FFFC, 32'h0, 5'd1, 1'b1, 1'b0, 32'h0000_0000);
        issue(3'd4, 32'h0, 32'h0000_1000, 32'h0000_2000, 5'd6, 1'b1, 1'b0, 32'h0000_3000);
        issue(3'd3, 32'h0, 32'h0000_1000, 32'hABCD_E000, 5'd7, 1'b1, 1'b0, 32'hABCD_E000);
        load(3'b000, 32'h0000_0102, 32'h0080_0000, 5'd8, 1'b1, 3, 0, 32'hFFFF_FF80);
        load(3'b100, 32'h0000_0102, 32'h0080_0000, 5'd9, 1'b1, 3, 0, 32'h0000_0080);
        load(3'b001, 32'h0000_0202, 32'h8001_0000, 5'd10, 1'b1, 1, 0, 32'hFFFF_8001);
        load(3'b101, 32'h0000_0202, 32'h8001_0000, 5'd11, 1'b1, 0, 0, 32'h0000_8001);
        load(3'b010, 32'h0000_0202, 32'h8001_0000, 5'd12, 1'b1, 2, 0, 32'h8001_0000);
        load(3'b000, 32'h0000_0300, 32'h1234_5678, 5'd13, 1'b1, 2, 1, 32'h0);
        issue(3'd0, 32'h1, 32'h0, 32'h0, 5'd2, 1'b1, 1'b1, 32'h0);
        idle(2);

        // Asynchronous reset while a load is outstanding.
        iValidM = 1'b1; iResultSrcM = 3'd1; iFunct3M = 3'b010; iRdM = 5'd14; iRegWriteM = 1'b1;
        @(posedge iClk); #1;
        iValidM = 1'b0;
        @(posedge iClk); #3;
        iRstN = 1'b0;
        #1;
        chk("async_rst_regwrite", 32'(oRegWriteW), 32'd0);
        chk("async_rst_rd", 32'(oRdW), 32'd0);
        chk("async_rst_data", oRegDataInW, 32'd0);
        chk("async_rst_busy", 32'(oBusyW), 32'd0);
        @(negedge iClk) iRstN = 1'b1;
        @(posedge iClk); #1;
        iMemRValid = 1'b1; iMemRData = 32'hDEAD_BEEF;
        @(posedge iClk); #1;
        iMemRValid = 1'b0;
        chk("stray_ready", 32'(oReadyM), 32'd1);
        idle(2);

        issue(3'd0, 32'h0000_00A1, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 32'h0000_00A1);
        issue(3'd0, 32'h0000_00B2, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 32'h0000_00B2);
        issue(3'd0, 32'h0000_00C3, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0000_00C3);
        idle(2);

        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 9);
            a  = $urandom; p = $urandom; im = $urandom; d = $urandom;
            rd = 5'($urandom);
            rw = ($urandom_range(0, 5) != 0);
            if (r < 5) begin
                src = $urandom_range(0, 7);
                if (src == 1) src = 0;
                fl = ($urandom_range(0, 9) == 0);
                issue(3'(src), a, p, im, rd, rw, fl, model(src, 0, a, p, im, 32'h0));
            end else if (r < 9) begin
                f3   = $urandom_range(0, 7);
                wc   = $urandom_range(0, 3);
                mode = $urandom_range(0, 9);
                mode = (mode < 8) ? 0 : mode - 7;
                load(3'(f3), a, d, rd, rw, wc, mode, model(1, f3, a, p, im, d));
            end else begin
                iMemRValid = 1'b1; iMemRData = d;
                @(posedge iClk); #1;
                iMemRValid = 1'b0;
            end
        end
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered writeback stage that replaces the purely combinational writeback result select.
- Accepts retiring instructions from the memory stage through a valid/ready handshake.
- Waits for a multi-cycle data-memory response on loads, then aligns and sign- or zero-extends the load data.
- Applies the result-source select and drives a one-cycle register-file write pulse plus a forwarding copy.

Parameters:
XLEN, 32, datapath width; must be 32 or 64.
RESULT_SRC_W, 3, width of the result-source select.
REG_ADDR_W, 5, register-file address width.

Ports:
iClk  input  1  clock, rising edge
iRstN  input  1  asynchronous active-low reset
iValidM  input  1  memory stage presents an instruction
oReadyM  output  1  stage can accept; high only in IDLE
iResultSrcM  input  RESULT_SRC_W  0 ALU, 1 MEM, 2 PC+4, 3 UpperImm, 4 PC+UpperImm, others ALU
iFunct3M  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
iAluResultM  input  XLEN  ALU result / load address
iPCM  input  XLEN  instruction PC
iUpperImmM  input  XLEN  U-type immediate
iRdM  input  REG_ADDR_W  destination register
iRegWriteM  input  1  instruction writes rd
iMemRValid  input  1  load data valid (single-cycle pulse)
iMemRData  input  XLEN  raw load word
iFlushW  input  1  kill pending/issuing writeback
oRegWriteW  output  1  register-file write enable pulse
oRdW  output  REG_ADDR_W  write address
oRegDataInW  output  XLEN  write data
oBusyW  output  1  load outstanding (state WAIT)

Behaviour:
- Reset (async assert, sync release): state IDLE; oRegWriteW=0, oRdW=0, oRegDataInW=0, oBusyW=0. oReadyM=1 once the state is IDLE.
- Accept = iValidM && oReadyM. All M-side inputs are captured into holding registers on accept.
- States:
  - IDLE: oReadyM=1.
    - Accept with non-load (iResultSrcM!=1) -> stay IDLE. Output registers load next edge, so latency is 1 cycle and back-to-back issue gives 1 instruction/cycle.
    - Accept with load -> WAIT. The byte offset iAluResultM[1:0], funct3, rd and regwrite are latched.
  - WAIT: oReadyM=0, oBusyW=1.
    - iMemRValid -> IDLE. Outputs load the extended data on the same edge, i.e. the write occurs in the cycle after iMemRValid.
- Outputs register every cycle: oRegWriteW = (issuing this edge) && captured regwrite && !iFlushW. oRdW and oRegDataInW update only when issuing; otherwise they hold.
- Writes to rd==0 are still issued; the register file ignores them.
- Result arithmetic: PC+4 and PC+UpperImm are modulo 2^XLEN and wrap with no carry-out.
- Load extraction, XLEN=32:
  - LB/LBU use byte offset[1:0]; LH/LHU use halfword offset[1]; LW ignores the offset.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 is treated as LW.
  - Misaligned halfword (offset[0]=1) uses offset[1] only; no trap.
- Load extraction, XLEN=64: same rules with offset[2:0]; LW sign-extends from bit 31.
- iFlushW:
  - In WAIT: -> IDLE immediately, pending load discarded, no write issued even if iMemRValid is high that same cycle.
  - In IDLE: suppresses the write of an instruction accepted that cycle.
- iMemRValid while IDLE is ignored (stray response).
- Simultaneous accept and flush: instruction dropped; oReadyM remains 1.
- Reset mid-WAIT: returns to IDLE; no write issued after release.

Decomposition:
- Shared package (e.g. riscv_pkg) holds:
  - result_src_e enum (ALU, MEM, PC4, UIMM, PCUIMM);
  - load_funct3_e enum (LB, LH, LW, LBU, LHU);
  - wb_state_e (IDLE, WAIT).
- Sub-module load_extend: combinational align plus sign/zero extension, parametrised by XLEN, inputs funct3/offset/raw word.
- The existing result select is reused inside the stage as the final mux.

Test Plan:
- Reset released; ALU op, rd=5, ALU=0x1234 accepted -> next cycle oRegWriteW=1, oRdW=5, oRegDataInW=0x00001234; following cycle oRegWriteW=0.
- JAL PC=0xFFFFFFFC, src=2 -> oRegDataInW=0x00000000 (wrap); AUIPC PC=0x1000, imm=0x00002000, src=4 -> 0x00003000.
- LB, addr offset 2, iMemRData=0x00800000 after 3 WAIT cycles -> oReadyM=0 and oBusyW=1 for those 3 cycles; result 0xFFFFFF80. Same word as LBU -> 0x00000080.
- LH offset 2, data 0x8001_0000 -> 0xFFFF8001; LHU -> 0x00008001; LW -> 0x80010000.
- Load pending, iFlushW and iMemRValid asserted together -> no oRegWriteW pulse; state IDLE; oReadyM=1 next cycle.
- iRstN asserted mid-WAIT, asynchronously -> outputs 0 immediately; a later iMemRValid causes no write.
- Three back-to-back ALU ops -> three consecutive write pulses with matching rd/data.
